// File: rtl/run_ctrl_if.sv
// Program-load stream between the host/boot side and the run controller.
interface run_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int INS_W  = 16
);
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [INS_W-1:0]  ld_data;
    logic              ld_last;

    modport master (
        output ld_valid, ld_addr, ld_data, ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_last,
        output ld_ready
    );
endinterface

// File: rtl/run_ctrl.sv
// Program loader and run sequencer: streams words into imem, holds the core
// in reset while loading, then gates its clock enable and watches for halt.
module run_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int INS_W      = 16,
    parameter int RST_CYCLES = 2,
    parameter int CYC_W      = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    run_ctrl_if.slave         ld,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [INS_W-1:0]  mem_wdata,
    output logic              cpu_rst,
    output logic              cpu_en,
    input  logic              halt_in,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              stop_req,
    input  logic              clr_req,
    output logic              halted,
    output logic              timed_out,
    output logic [CYC_W-1:0]  cycles
);
    typedef enum logic [2:0] {
        IDLE, LOAD, CPURST, PAUSED, RUN, STEP, HALTED
    } state_t;

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [RC_W-1:0]  RC_ONE  = RC_W'(1);
    localparam logic [CYC_W:0]   TO_VAL  = (CYC_W + 1)'(TIMEOUT);
    localparam logic [CYC_W:0]   CYC_ONE = (CYC_W + 1)'(1);
    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    state_t            state, state_d;
    logic [RC_W-1:0]   rcnt, rcnt_d;
    logic              ready_d, we_d, crst_d, en_d;
    logic [ADDR_W-1:0] addr_d;
    logic [INS_W-1:0]  data_d;
    logic              halted_d, to_d;
    logic [CYC_W-1:0]  cycles_d;
    logic [CYC_W:0]    cyc_inc;
    logic              xfer, hit_to;

    assign xfer    = ld.ld_valid && ld.ld_ready;
    assign cyc_inc = {1'b0, cycles} + CYC_ONE;
    assign hit_to  = (TIMEOUT != 0) && (cyc_inc == TO_VAL);

    always_comb begin
        state_d  = state;
        rcnt_d   = rcnt;
        we_d     = 1'b0;
        addr_d   = mem_waddr;
        data_d   = mem_wdata;
        halted_d = halted;
        to_d     = timed_out;
        cycles_d = cycles;
        unique case (state)
            IDLE, LOAD: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = ld.ld_addr;
                    data_d  = ld.ld_data;
                    rcnt_d  = '0;
                    state_d = ld.ld_last ? CPURST : LOAD;
                end
            end
            CPURST: begin
                cycles_d = '0;
                halted_d = 1'b0;
                to_d     = 1'b0;
                if (rcnt == RC_LAST) state_d = PAUSED;
                else rcnt_d = rcnt + RC_ONE;
            end
            PAUSED: begin
                if (clr_req)       state_d = IDLE;
                else if (run_req)  state_d = RUN;
                else if (step_req) state_d = STEP;
            end
            RUN, STEP: begin
                // the enabled cycle counts even when it is the halting one
                if (cycles != CYC_MAX) cycles_d = cyc_inc[CYC_W-1:0];
                if (halt_in) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                end else if (hit_to) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                    to_d     = 1'b1;
                end else if (state == STEP || stop_req) begin
                    state_d = PAUSED;
                end
            end
            HALTED: begin
                if (clr_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) || (state_d == LOAD);
        crst_d  = ready_d || (state_d == CPURST);
        en_d    = (state_d == RUN) || (state_d == STEP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rcnt        <= '0;
            ld.ld_ready <= 1'b0;
            mem_we      <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            cpu_rst     <= 1'b1;
            cpu_en      <= 1'b0;
            halted      <= 1'b0;
            timed_out   <= 1'b0;
            cycles      <= '0;
        end else begin
            state       <= state_d;
            rcnt        <= rcnt_d;
            ld.ld_ready <= ready_d;
            mem_we      <= we_d;
            mem_waddr   <= addr_d;
            mem_wdata   <= data_d;
            cpu_rst     <= crst_d;
            cpu_en      <= en_d;
            halted      <= halted_d;
            timed_out   <= to_d;
            cycles      <= cycles_d;
        end
    end
endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: a phase-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_run_ctrl;
    localparam int ADDR_W     = 10;
    localparam int INS_W      = 16;
    localparam int RST_CYCLES = 2;
    localparam int CYC_W      = 32;
    localparam int TIMEOUT    = 8;
    localparam longint CYC_MAX = (longint'(1) << CYC_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [INS_W-1:0] mem_wdata;
    logic             cpu_rst, cpu_en, halt_in;
    logic             run_req, step_req, stop_req, clr_req;
    logic             halted, timed_out;
    logic [CYC_W-1:0] cycles;

    run_ctrl_if #(.ADDR_W(ADDR_W), .INS_W(INS_W)) ld ();

    run_ctrl #(
        .ADDR_W(ADDR_W), .INS_W(INS_W), .RST_CYCLES(RST_CYCLES),
        .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .ld(ld),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .halt_in(halt_in),
        .run_req(run_req), .step_req(step_req), .stop_req(stop_req),
        .clr_req(clr_req), .halted(halted), .timed_out(timed_out),
        .cycles(cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int en_seen = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // model: which phase the controller is in, and what it must show
    bit     m_acc, m_paused, m_run, m_step, m_hlt;
    int     m_rleft;
    bit     e_ready, e_we, e_crst, e_en, e_halted, e_to;
    longint e_waddr, e_wdata, e_cyc;

    task automatic model_step();
        bit en;
        bit to_hit;
        en   = m_run || m_step;
        e_we = 1'b0;
        if (rst) begin
            m_acc = 1; m_rleft = 0; m_paused = 0;
            m_run = 0; m_step = 0; m_hlt = 0;
            e_ready = 0; e_waddr = 0; e_wdata = 0; e_crst = 1;
            e_en = 0; e_halted = 0; e_to = 0; e_cyc = 0;
            return;
        end
        if (m_acc) begin
            if (ld.ld_valid && e_ready) begin
                e_we = 1; e_waddr = ld.ld_addr; e_wdata = ld.ld_data;
                if (ld.ld_last) begin
                    m_acc = 0;
                    m_rleft = RST_CYCLES;
                end
            end
        end else if (m_rleft > 0) begin
            e_cyc = 0; e_halted = 0; e_to = 0;
            m_rleft--;
            if (m_rleft == 0) m_paused = 1;
        end else if (m_paused) begin
            if (clr_req) begin m_paused = 0; m_acc = 1; end
            else if (run_req) begin m_paused = 0; m_run = 1; end
            else if (step_req) begin m_paused = 0; m_step = 1; end
        end else if (en) begin
            to_hit = (TIMEOUT != 0) && (e_cyc + 1 == TIMEOUT);
            if (e_cyc < CYC_MAX) e_cyc++;
            if (halt_in) begin
                m_run = 0; m_step = 0; m_hlt = 1; e_halted = 1;
            end else if (to_hit) begin
                m_run = 0; m_step = 0; m_hlt = 1; e_halted = 1; e_to = 1;
            end else if (m_step || stop_req) begin
                m_run = 0; m_step = 0; m_paused = 1;
            end
        end else if (m_hlt) begin
            if (clr_req) begin m_hlt = 0; m_acc = 1; end
        end
        e_ready = m_acc;
        e_crst  = m_acc || (m_rleft > 0);
        e_en    = m_run || m_step;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("ld_ready", 64'(ld.ld_ready), 64'(e_ready));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        if (e_we) begin
            chk("mem_waddr", 64'(mem_waddr), e_waddr);
            chk("mem_wdata", 64'(mem_wdata), e_wdata);
        end
        chk("cpu_rst", 64'(cpu_rst), 64'(e_crst));
        chk("cpu_en", 64'(cpu_en), 64'(e_en));
        chk("halted", 64'(halted), 64'(e_halted));
        chk("timed_out", 64'(timed_out), 64'(e_to));
        chk("cycles", 64'(cycles), e_cyc);
        if (cpu_en === 1'b1) en_seen++;
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(logic [ADDR_W-1:0] a, logic [INS_W-1:0] d, bit last);
        bit done;
        done = 0;
        ld.ld_valid = 1; ld.ld_addr = a; ld.ld_data = d; ld.ld_last = last;
        for (int i = 0; i < 20 && !done; i++) begin
            done = ld.ld_ready;
            @(negedge clk);
        end
        chk("load_accept", 64'(done), 64'd1);
    endtask

    int en0;

    initial begin
        rst = 1; halt_in = 0;
        run_req = 0; step_req = 0; stop_req = 0; clr_req = 0;
        ld.ld_valid = 0; ld.ld_addr = '0; ld.ld_data = '0; ld.ld_last = 0;
        cyc(3);
        chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst_cpu_en", 64'(cpu_en), 64'd0);
        chk("rst_ready", 64'(ld.ld_ready), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        rst = 0;
        cyc(1);
        chk("ready_after_rst", 64'(ld.ld_ready), 64'd1);

        send(10'd0, 16'h006F, 0);
        chk("w0_we", 64'(mem_we), 64'd1);
        chk("w0_addr", 64'(mem_waddr), 64'd0);
        chk("w0_data", 64'(mem_wdata), 64'h006F);
        send(10'd1, 16'h6F10, 1);
        chk("w1_we", 64'(mem_we), 64'd1);
        chk("w1_addr", 64'(mem_waddr), 64'd1);
        chk("w1_data", 64'(mem_wdata), 64'h6F10);
        chk("w1_ready", 64'(ld.ld_ready), 64'd0);
        // a word offered while not ready must be held off
        ld.ld_addr = 10'd2; ld.ld_data = 16'hDEAD; ld.ld_last = 0;
        cyc(1);
        chk("crst2_rst", 64'(cpu_rst), 64'd1);
        chk("crst2_we", 64'(mem_we), 64'd0);
        cyc(1);
        chk("paused_rst", 64'(cpu_rst), 64'd0);
        chk("paused_cyc", 64'(cycles), 64'd0);
        ld.ld_valid = 0;

        en0 = en_seen;
        for (int i = 0; i < 3; i++) begin
            step_req = 1; cyc(1); step_req = 0; cyc(2);
        end
        chk("step_pulses", 64'(en_seen - en0), 64'd3);
        chk("step_cycles", 64'(cycles), 64'd3);

        run_req = 1; cyc(1); run_req = 0;
        stop_req = 1; cyc(1); stop_req = 0;
        chk("stop_en", 64'(cpu_en), 64'd0);
        chk("stop_cycles", 64'(cycles), 64'd4);
        halt_in = 1; cyc(2); halt_in = 0;
        chk("paused_halt_ign", 64'(halted), 64'd0);

        clr_req = 1; cyc(1); clr_req = 0;
        chk("clr_ready", 64'(ld.ld_ready), 64'd1);
        send(10'd5, 16'h1234, 1);
        ld.ld_valid = 0;
        cyc(2);
        chk("reload_cycles", 64'(cycles), 64'd0);

        en0 = en_seen;
        run_req = 1; step_req = 1; cyc(1); run_req = 0; step_req = 0;
        cyc(4);
        halt_in = 1; cyc(1); halt_in = 0;
        chk("halt_cycles", 64'(cycles), 64'd5);
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_to", 64'(timed_out), 64'd0);
        chk("halt_en", 64'(cpu_en), 64'd0);
        chk("halt_pulses", 64'(en_seen - en0), 64'd5);

        clr_req = 1; cyc(1); clr_req = 0;
        chk("halted_clr_ready", 64'(ld.ld_ready), 64'd1);
        send(10'd9, 16'h0F0F, 1);
        ld.ld_valid = 0;
        cyc(2);
        en0 = en_seen;
        run_req = 1; cyc(1); run_req = 0;
        cyc(12);
        chk("to_pulses", 64'(en_seen - en0), 64'd8);
        chk("to_cycles", 64'(cycles), 64'd8);
        chk("to_halted", 64'(halted), 64'd1);
        chk("to_flag", 64'(timed_out), 64'd1);

        clr_req = 1; cyc(1); clr_req = 0;
        ld.ld_valid = 1; ld.ld_addr = 10'd7; ld.ld_data = 16'hAAAA; ld.ld_last = 0;
        cyc(1);
        chk("mid_we", 64'(mem_we), 64'd1);
        chk("mid_addr", 64'(mem_waddr), 64'd7);
        ld.ld_addr = 10'd8; ld.ld_data = 16'hBBBB;
        rst = 1;
        cyc(1);
        chk("mid_rst_we", 64'(mem_we), 64'd0);
        chk("mid_rst_ready", 64'(ld.ld_ready), 64'd0);
        chk("mid_rst_cycles", 64'(cycles), 64'd0);
        cyc(1);
        chk("mid_rst_we2", 64'(mem_we), 64'd0);
        rst = 0; ld.ld_valid = 0;
        cyc(2);
        chk("mid_rst_ready2", 64'(ld.ld_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
